// File: rtl/fft_core.sv
// 32-point real-input DFT: collects 32 samples, then streams Re[0..31] and Im[0..31].
// Each output word is computed directly from the stored frame against a constant twiddle table.
module fft_core (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic signed [10:0] x_r,
    output logic               finish,
    output logic signed [16:0] answer
);

    typedef enum logic [1:0] {
        ST_INPUT  = 2'd0,
        ST_CALC   = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [5:0]         out_idx_q, out_idx_d;
    logic               finish_q, finish_d;
    logic signed [16:0] answer_q, answer_d;
    logic               mem_we_s;
    logic               mem_clr_s;
    logic signed [10:0] x_mem_q [32];
    logic signed [26:0] acc_s;
    logic signed [26:0] rounded_s;
    logic [9:0]         unused_lsb_s;

    // First-octant cosine magnitudes, round(1024*cos(2*pi*q/32)) for q = 0..8.
    function automatic logic signed [11:0] cos_base(input logic [3:0] q);
        case (q)
            4'd0:    return 12'sd1024;
            4'd1:    return 12'sd1004;
            4'd2:    return 12'sd946;
            4'd3:    return 12'sd851;
            4'd4:    return 12'sd724;
            4'd5:    return 12'sd569;
            4'd6:    return 12'sd392;
            4'd7:    return 12'sd200;
            default: return 12'sd0;
        endcase
    endfunction

    function automatic logic signed [11:0] tw_re(input logic [4:0] m);
        if (m <= 5'd8) begin
            return cos_base(m[3:0]);
        end else if (m <= 5'd16) begin
            return -cos_base(4'(5'd16 - m));
        end else if (m <= 5'd24) begin
            return -cos_base(4'(m - 5'd16));
        end else begin
            return cos_base(4'(5'd0 - m));
        end
    endfunction

    // -sin(2*pi*m/32) equals -cos(2*pi*(m-8)/32).
    function automatic logic signed [11:0] tw_coef(input logic sel_im, input logic [4:0] m);
        if (sel_im) begin
            return -tw_re(m + 5'd24);
        end else begin
            return tw_re(m);
        end
    endfunction

    // Output word out_idx_q: index bit 5 selects Im, bits 4:0 give k.
    always_comb begin
        acc_s = 27'sd0;
        for (int n = 0; n < 32; n++) begin
            acc_s = acc_s + 27'(x_mem_q[n]) *
                    27'(tw_coef(out_idx_q[5], 5'(5'(n) * out_idx_q[4:0])));
        end
        rounded_s    = acc_s + 27'sd512;
        unused_lsb_s = rounded_s[9:0];
    end

    // Frame sequencing: capture, one-cycle CALC, then 64 output words.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_idx_d = out_idx_q;
        finish_d  = 1'b0;
        answer_d  = 17'sd0;
        mem_we_s  = 1'b0;
        mem_clr_s = 1'b0;
        case (state_q)
            ST_INPUT: begin
                if (valid_i) begin
                    mem_we_s = 1'b1;
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_INPUT;
                    end
                end else begin
                    state_d = ST_INPUT;
                end
            end
            ST_CALC: begin
                finish_d  = 1'b1;
                answer_d  = rounded_s[26:10];
                out_idx_d = 6'd1;
                state_d   = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                // out_idx wraps to 0 once word 63 has been loaded.
                if (out_idx_q == 6'd0) begin
                    state_d   = ST_INPUT;
                    cnt_d     = 5'd0;
                    mem_clr_s = 1'b1;
                end else begin
                    finish_d  = 1'b1;
                    answer_d  = rounded_s[26:10];
                    out_idx_d = out_idx_q + 6'd1;
                end
            end
            default: begin
                state_d   = ST_INPUT;
                cnt_d     = 5'd0;
                out_idx_d = 6'd0;
                mem_clr_s = 1'b1;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ST_INPUT;
            cnt_q     <= 5'd0;
            out_idx_q <= 6'd0;
            finish_q  <= 1'b0;
            answer_q  <= 17'sd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_idx_q <= out_idx_d;
            finish_q  <= finish_d;
            answer_q  <= answer_d;
        end
    end

    // Sample memory, cleared between frames so frames stay independent.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) begin
                x_mem_q[i] <= 11'sd0;
            end
        end else if (mem_clr_s) begin
            for (int i = 0; i < 32; i++) begin
                x_mem_q[i] <= 11'sd0;
            end
        end else if (mem_we_s) begin
            x_mem_q[cnt_q] <= x_r;
        end
    end

    assign finish = finish_q;
    assign answer = answer_q;

endmodule

// File: tb/tb_fft_core.sv
// Self-checking bench for fft_core: a DFT reference model fills a scoreboard queue,
// and a monitor pops and compares every word the DUT presents.
module tb_fft_core;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid_i;
    logic signed [10:0] x_r;
    logic               finish;
    logic signed [16:0] answer;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int twr[32];
    int twi[32];
    int run_len = 0;

    always #5 clk = ~clk;

    fft_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .x_r     (x_r),
        .finish  (finish),
        .answer  (answer)
    );

    function automatic int round_away(input real v);
        if (v >= 0.0) return int'($floor(v + 0.5));
        else          return -int'($floor(-v + 0.5));
    endfunction

    function automatic void init_twiddles();
        real ang;
        for (int m = 0; m < 32; m++) begin
            ang    = 2.0 * 3.14159265358979323846 * m / 32.0;
            twr[m] = round_away(1024.0 * $cos(ang));
            twi[m] = round_away(-1024.0 * $sin(ang));
        end
    endfunction

    // Direct DFT definition; Re words queued first, then Im words.
    function automatic void model_push(input int xs[32]);
        longint sr, si;
        int re[32];
        int im[32];
        for (int k = 0; k < 32; k++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < 32; n++) begin
                sr += longint'(xs[n]) * twr[(n * k) % 32];
                si += longint'(xs[n]) * twi[(n * k) % 32];
            end
            re[k] = int'((sr + 512) >>> 10);
            im[k] = int'((si + 512) >>> 10);
        end
        for (int k = 0; k < 32; k++) exp_q.push_back(re[k]);
        for (int k = 0; k < 32; k++) exp_q.push_back(im[k]);
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        int e;
        if (rst_n) begin
            run_len = 0;
        end else if (finish) begin
            run_len++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: answer=%0d with no word expected", answer);
            end else begin
                e = exp_q.pop_front();
                if (int'(answer) !== e) begin
                    errors++;
                    $display("FAIL word%0d: got %0d expected %0d", run_len - 1, answer, e);
                end
            end
        end else begin
            if (run_len != 0) begin
                checks++;
                if (run_len != 64) begin
                    errors++;
                    $display("FAIL burst_len: got %0d expected 64", run_len);
                end
                run_len = 0;
            end
            checks++;
            if (answer !== 17'sd0) begin
                errors++;
                $display("FAIL idle_zero: got %0d expected 0", answer);
            end
        end
    end

    // gap_mode: 0 none, 1 alternate idle cycles, 2 random idle cycles.
    task automatic drive_frame(input int xs[32], input int gap_mode);
        for (int n = 0; n < 32; n++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(1) == 1)) begin
                valid_i = 1'b0;
                x_r     = 11'($urandom);
                @(negedge clk);
            end
            valid_i = 1'b1;
            x_r     = 11'(xs[n]);
            @(negedge clk);
        end
        model_push(xs);
    endtask

    // Keeps garbage on the inputs while the frame is processed; returns once finish drops.
    task automatic wait_output();
        int  cyc  = 0;
        bit  seen = 1'b0;
        bit  done = 1'b0;
        while (cyc < 200 && !done) begin
            valid_i = 1'($urandom_range(1));
            x_r     = 11'($urandom);
            cyc++;
            @(negedge clk);
            if (finish && !seen) begin
                seen = 1'b1;
                checks++;
                if (cyc > 10) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles expected <= 10", cyc);
                end
            end
            if (seen && !finish) done = 1'b1;
        end
        valid_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: finish seen=%0d still high=%0d", seen, finish);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d words expected but not delivered", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (finish !== 1'b0 || answer !== 17'sd0) begin
            errors++;
            $display("FAIL async_reset: finish=%0d answer=%0d expected 0 0", finish, answer);
        end
        @(negedge clk);
        exp_q.delete();
        #1 rst_n = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int xs[32];
        int cyc;
        init_twiddles();
        rst_n   = 1'b1;
        valid_i = 1'b0;
        x_r     = 11'sd0;
        #3;
        checks++;
        if (finish !== 1'b0 || answer !== 17'sd0) begin
            errors++;
            $display("FAIL reset_state: finish=%0d answer=%0d expected 0 0", finish, answer);
        end
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);

        foreach (xs[i]) xs[i] = (i == 0) ? 1 : 0;
        drive_frame(xs, 0);
        wait_output();

        foreach (xs[i]) xs[i] = -1024;
        drive_frame(xs, 0);
        wait_output();

        foreach (xs[i]) xs[i] = (i % 2 == 0) ? 100 : -100;
        drive_frame(xs, 0);
        wait_output();

        foreach (xs[i]) xs[i] = (i == 0) ? 1 : 0;
        drive_frame(xs, 1);
        wait_output();

        foreach (xs[i]) xs[i] = 1;
        drive_frame(xs, 0);
        wait_output();
        foreach (xs[i]) xs[i] = (i % 2 == 0) ? 100 : -100;
        drive_frame(xs, 0);
        wait_output();

        for (int n = 0; n < 10; n++) begin
            valid_i = 1'b1;
            x_r     = 11'($urandom);
            @(negedge clk);
        end
        valid_i = 1'b0;
        pulse_reset();
        foreach (xs[i]) xs[i] = (i == 0) ? 1 : 0;
        drive_frame(xs, 0);
        wait_output();

        foreach (xs[i]) xs[i] = int'($urandom_range(2047)) - 1024;
        drive_frame(xs, 0);
        valid_i = 1'b0;
        cyc = 0;
        while (!finish && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        pulse_reset();
        repeat (3) @(negedge clk);

        for (int f = 0; f < 4; f++) begin
            foreach (xs[i]) xs[i] = int'($urandom_range(2047)) - 1024;
            drive_frame(xs, 2);
            wait_output();
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_core.md
FFT_CORE -- requirements
Module: FFT

Interface
REQ-001 The block SHALL expose port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL expose port rst_n, input, 1 bit, reset: asynchronous, active-high, with the port name kept as in the codebase.
REQ-003 The block SHALL expose port valid_i, input, 1 bit, qualifying x_r as a valid input sample in that cycle.
REQ-004 The block SHALL expose port x_r, input, 11 bits, the real input sample, two's complement integer in the range -1024..1023.
REQ-005 The block SHALL expose port finish, output, 1 bit, high in every cycle in which answer carries a valid output word.
REQ-006 The block SHALL expose port answer, output, 17 bits, the output word, two's complement integer.
REQ-007 The block SHALL have no parameters; N=32 is fixed.

Function
REQ-008 The block SHALL compute the 32-point DFT of a real 32-sample frame: X[k] = sum over n=0..31 of x[n]·e^(-j2πnk/32).
REQ-009 Twiddle constants SHALL be, for m=0..31:
- Cr[m] = round(1024·cos(2πm/32))
- Ci[m] = round(-1024·sin(2πm/32))
- 12-bit signed, rounding half away from zero.
REQ-010 Output definition, bit-exact, with m=(n·k) mod 32:
- Re[k] = (Σ x[n]·Cr[m] + 512) >>> 10
- Im[k] = (Σ x[n]·Ci[m] + 512) >>> 10
- Sums are accumulated at full precision, at least 27 bits signed.
- >>> is an arithmetic right shift.
- There is no intermediate rounding.
REQ-011 Sample capture: on each rising edge with valid_i=1 in the INPUT state, x_r SHALL be captured as x[cnt] and cnt SHALL increment.
REQ-012 Cycles with valid_i=0 in the INPUT state SHALL be ignored; gaps between samples are allowed.
REQ-013 States SHALL be IDLE/INPUT (shared, cnt=0..31), CALC, and OUTPUT.
REQ-014 When the 32nd sample (cnt=31) is captured, the block SHALL leave INPUT.
REQ-015 The CALC state SHALL last at most 8 cycles.
REQ-016 The OUTPUT state SHALL hold finish high for exactly 64 consecutive cycles, then return to INPUT with cnt=0.
REQ-017 Output order SHALL be Re[0], Re[1], …, Re[31], then Im[0], …, Im[31], one word per cycle in natural (non-bit-reversed) order.
REQ-018 answer and finish SHALL be registered outputs, changing only after a rising edge.
REQ-019 The first finish=1 SHALL occur no later than 10 cycles after the edge that captures x[31].
REQ-020 valid_i SHALL be ignored during CALC and OUTPUT; samples presented then are dropped.
REQ-021 A new frame SHALL be accepted starting on the cycle after the 64th output word.
REQ-022 When finish=0, answer SHALL be 0.
REQ-023 The output range is ±32768, so answer SHALL never overflow 17 bits and no saturation logic is required.
REQ-024 Internal frame state (accumulators or sample memory) SHALL be cleared before each new frame, so frames are independent.

Reset
REQ-025 While rst_n=1, the block SHALL be in INPUT with cnt=0, finish=0, answer=0, and all accumulators and sample storage cleared.
REQ-026 Assertion of rst_n in any state SHALL immediately abort the frame in progress without waiting for a clock edge.
REQ-027 After rst_n is released, the first valid_i=1 edge SHALL capture x[0].

Verification
REQ-028 Impulse: x[0]=1, others 0 -> Re[k]=1 for all k, Im[k]=0 for all k; finish high for exactly 64 cycles.
REQ-029 DC extreme: all x[n]=-1024 -> Re[0]=-32768, all other 63 words 0.
REQ-030 Nyquist: x[n]=100·(-1)^n -> Re[16]=3200, all other words 0.
REQ-031 Gapped input: the impulse frame delivered with valid_i low on alternate cycles -> output identical to REQ-028.
REQ-032 Back-to-back frames: DC frame x[n]=1 (Re[0]=32, others 0), then the REQ-030 frame -> both outputs correct, with no carry-over between frames.
REQ-033 Reset mid-frame: rst_n pulsed after 10 samples, then a full impulse frame -> output matches REQ-028 and finish stays 0 until then.
